// File: rtl/ifu_fetch_queue.sv
// Instruction fetch front end: drives the MMU inst channel and buffers returned
// {pc, inst} pairs for decode. Define IFQ_PERF_CNT_EN to add performance counters.
module ifu_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_en,
  output logic [31:0] inst_addr,
  input  logic        inst_ok,
  input  logic        inst_ok_1,
  input  logic        inst_ok_2,
  input  logic [31:0] inst_data_1,
  input  logic [31:0] inst_data_2,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid_1,
  output logic [31:0] out_inst_1,
  output logic [31:0] out_pc_1,
  output logic        out_valid_2,
  output logic [31:0] out_inst_2,
  output logic [31:0] out_pc_2,
  input  logic [1:0]  deq_num
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_full_cyc
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_SPACE, DISCARD} state_t;

  state_t        state;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [31:0]   target;

  logic [1:0]    wr_num, pop_num, deq_req;
  logic [AW:0]   count_next;
  logic          space_ok;
  logic [31:0]   flush_tgt, addr_step;
  logic [AW-1:0] head_p1, tail_p1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_num    = 2'd0;
    pop_num   = 2'd0;
    deq_req   = (deq_num == 2'd3) ? 2'd2 : deq_num;
    flush_tgt = flush_pc & ~32'h3;
    addr_step = inst_ok_1 ? (inst_ok_2 ? 32'd8 : 32'd4) : 32'd0;
    head_p1   = head + 1'b1;
    tail_p1   = tail + 1'b1;

    if (state == FETCH && inst_ok && !flush && inst_ok_1)
      wr_num = inst_ok_2 ? 2'd2 : 2'd1;

    // An over-sized dequeue is clamped to what is actually held.
    if (!flush)
      pop_num = (count < (AW+1)'(deq_req)) ? count[1:0] : deq_req;

    count_next = flush ? '0 : count + (AW+1)'(wr_num) - (AW+1)'(pop_num);
    space_ok   = count_next <= (AW+1)'(DEPTH - 2);
  end

  assign out_valid_1 = count >= (AW+1)'(1);
  assign out_valid_2 = count >= (AW+1)'(2);
  assign out_pc_1    = pc_mem[head];
  assign out_inst_1  = inst_mem[head];
  assign out_pc_2    = pc_mem[head_p1];
  assign out_inst_2  = inst_mem[head_p1];

  // NOTE: queue storage has no reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_num != 2'd0) begin
      pc_mem[tail]   <= inst_addr;
      inst_mem[tail] <= inst_data_1;
    end
    if (wr_num == 2'd2) begin
      pc_mem[tail_p1]   <= inst_addr + 32'd4;
      inst_mem[tail_p1] <= inst_data_2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      inst_en   <= 1'b0;
      inst_addr <= RESET_PC;
      target    <= RESET_PC;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
    end else begin
      count <= count_next;
      tail  <= tail + AW'(wr_num);
      head  <= flush ? tail : head + AW'(pop_num);

      case (state)
        IDLE: begin
          state   <= FETCH;
          inst_en <= 1'b1;
          if (flush) begin
            target    <= flush_tgt;
            inst_addr <= flush_tgt;
          end
        end
        FETCH: begin
          if (flush) begin
            target <= flush_tgt;
            if (inst_ok) begin
              inst_addr <= flush_tgt;
              state     <= FETCH;
            end else begin
              // The MMU still owns the old address; its reply must be absorbed first.
              state <= DISCARD;
            end
            inst_en <= 1'b1;
          end else if (inst_ok) begin
            inst_addr <= inst_addr + addr_step;
            state     <= space_ok ? FETCH : WAIT_SPACE;
            inst_en   <= space_ok;
          end
        end
        WAIT_SPACE: begin
          if (flush) begin
            target    <= flush_tgt;
            inst_addr <= flush_tgt;
            state     <= FETCH;
            inst_en   <= 1'b1;
          end else if (space_ok) begin
            state   <= FETCH;
            inst_en <= 1'b1;
          end
        end
        DISCARD: begin
          if (flush) target <= flush_tgt;
          if (inst_ok) begin
            inst_addr <= flush ? flush_tgt : target;
            state     <= FETCH;
          end
          inst_en <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          inst_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFQ_PERF_CNT_EN
  // Flush deliberately leaves these running totals untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_full_cyc  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(wr_num);
      perf_full_cyc  <= perf_full_cyc + 32'(state == WAIT_SPACE);
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Scoreboard bench for ifu_fetch_queue: stimulus pushes expected {pc, inst}
// entries, a negedge monitor compares them as decode consumes them.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic        inst_ok, inst_ok_1, inst_ok_2;
  logic [31:0] inst_data_1, inst_data_2;
  logic        flush;
  logic [31:0] flush_pc;
  logic        out_valid_1, out_valid_2;
  logic [31:0] out_inst_1, out_pc_1, out_inst_2, out_pc_2;
  logic [1:0]  deq_num;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_full_cyc;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  ifu_fetch_queue #(.DEPTH(8), .RESET_PC(32'hBFC00000)) dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr),
    .inst_ok(inst_ok), .inst_ok_1(inst_ok_1), .inst_ok_2(inst_ok_2),
    .inst_data_1(inst_data_1), .inst_data_2(inst_data_2),
    .flush(flush), .flush_pc(flush_pc),
    .out_valid_1(out_valid_1), .out_inst_1(out_inst_1), .out_pc_1(out_pc_1),
    .out_valid_2(out_valid_2), .out_inst_2(out_inst_2), .out_pc_2(out_pc_2),
    .deq_num(deq_num)
`ifdef IFQ_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_full_cyc(perf_full_cyc)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every entry decode consumes against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && deq_num != 2'd0) begin
      for (int i = 0; i < int'(deq_num); i++) begin
        logic        v;
        logic [63:0] got;
        v   = (i == 0) ? out_valid_1 : out_valid_2;
        got = (i == 0) ? {out_pc_1, out_inst_1} : {out_pc_2, out_inst_2};
        if (!v) begin
          vectors++;
          miscompares++;
          $display("FAIL deq_over_count: slot %0d not valid, deq_num %0d", i, deq_num);
        end else if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_empty: got %h expected nothing", got);
        end else begin
          check("sb_entry", got, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_en();
    int n = 0;
    while (inst_en !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("inst_en_wait", 64'(inst_en), 64'd1);
  endtask

  task automatic deq(input logic [1:0] n);
    deq_num = n;
    tick();
    deq_num = 2'd0;
  endtask

  task automatic mmu_respond(input int delay, input logic [31:0] pc, input logic ok1, input logic ok2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [1:0] deq, input bit keep);
    wait_en();
    repeat (delay) tick();
    check("inst_addr_req", 64'(inst_addr), 64'(pc));
    inst_ok = 1'b1; inst_ok_1 = ok1; inst_ok_2 = ok2;
    inst_data_1 = d1; inst_data_2 = d2; deq_num = deq;
    if (keep && ok1) exp_q.push_back({pc, d1});
    if (keep && ok1 && ok2) exp_q.push_back({pc + 32'd4, d2});
    tick();
    inst_ok = 1'b0; inst_ok_1 = 1'b0; inst_ok_2 = 1'b0; deq_num = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; inst_ok = 1'b0; inst_ok_1 = 1'b0; inst_ok_2 = 1'b0;
    inst_data_1 = '0; inst_data_2 = '0; flush = 1'b0; flush_pc = '0; deq_num = 2'd0;
    repeat (3) tick();
    check("rst_inst_en",   64'(inst_en),     64'd0);
    check("rst_inst_addr", 64'(inst_addr),   64'hBFC00000);
    check("rst_valid_1",   64'(out_valid_1), 64'd0);
    check("rst_valid_2",   64'(out_valid_2), 64'd0);
    rst = 1'b0;

    // First dual fetch, 3-cycle MMU latency
    mmu_respond(3, 32'hBFC00000, 1, 1, 32'h11, 32'h22, 2'd0, 1);
    check("first_addr",  64'(inst_addr), 64'hBFC00008);
    check("first_v2",    64'(out_valid_2), 64'd1);
    check("first_head",  {out_pc_1, out_inst_1}, {32'hBFC00000, 32'h11});
    check("first_next",  {out_pc_2, out_inst_2}, {32'hBFC00004, 32'h22});
    deq(2);

    // Mixed dual and single returns
    mmu_respond(1, 32'hBFC00008, 1, 1, 32'h33, 32'h44, 2'd0, 1);
    mmu_respond(0, 32'hBFC00010, 1, 1, 32'h55, 32'h66, 2'd0, 1);
    mmu_respond(0, 32'hBFC00018, 1, 0, 32'h77, 32'h0,  2'd0, 1);
    mmu_respond(0, 32'hBFC0001C, 1, 0, 32'h88, 32'h0,  2'd0, 1);
    check("single_addr", 64'(inst_addr), 64'hBFC00020);
    check("six_held_en", 64'(inst_en), 64'd1);
    deq(2); deq(2); deq(2);
    check("drained_empty", 64'(out_valid_1), 64'd0);

    // Fill to DEPTH with no consumption
    mmu_respond(0, 32'hBFC00020, 1, 1, 32'hA0, 32'hA1, 2'd0, 1);
    mmu_respond(0, 32'hBFC00028, 1, 1, 32'hA2, 32'hA3, 2'd0, 1);
    mmu_respond(0, 32'hBFC00030, 1, 1, 32'hA4, 32'hA5, 2'd0, 1);
    check("count6_en", 64'(inst_en), 64'd1);
    mmu_respond(0, 32'hBFC00038, 1, 1, 32'hA6, 32'hA7, 2'd0, 1);
    check("full_wait_en", 64'(inst_en), 64'd0);
    check("full_v2",      64'(out_valid_2), 64'd1);
    deq(2);
    check("refill_en",   64'(inst_en), 64'd1);
    check("refill_addr", 64'(inst_addr), 64'hBFC00040);

    // Flush with a request outstanding: reply must be discarded
    flush = 1'b1; flush_pc = 32'h80001003; exp_q.delete();
    tick();
    flush = 1'b0;
    check("flush_empty",    64'(out_valid_1), 64'd0);
    check("flush_en",       64'(inst_en), 64'd1);
    check("flush_addr_old", 64'(inst_addr), 64'hBFC00040);
    mmu_respond(2, 32'hBFC00040, 1, 1, 32'hDEAD0001, 32'hDEAD0002, 2'd0, 0);
    check("discard_empty", 64'(out_valid_1), 64'd0);
    check("discard_addr",  64'(inst_addr), 64'h80001000);
    check("discard_en",    64'(inst_en), 64'd1);

    // Flush in the same cycle as inst_ok
    wait_en();
    tick(); tick();
    inst_ok = 1'b1; inst_ok_1 = 1'b1; inst_ok_2 = 1'b1;
    inst_data_1 = 32'hBAD1; inst_data_2 = 32'hBAD2;
    flush = 1'b1; flush_pc = 32'h80001001; exp_q.delete();
    tick();
    inst_ok = 1'b0; inst_ok_1 = 1'b0; inst_ok_2 = 1'b0; flush = 1'b0;
    check("flush_ok_empty", 64'(out_valid_1), 64'd0);
    check("flush_ok_en",    64'(inst_en), 64'd1);
    check("flush_ok_addr",  64'(inst_addr), 64'h80001000);

    // Tail wrap with simultaneous write and pop
    mmu_respond(0, 32'h80001000, 1, 1, 32'hC0, 32'hC1, 2'd0, 1);
    mmu_respond(0, 32'h80001008, 1, 1, 32'hC2, 32'hC3, 2'd0, 1);
    mmu_respond(0, 32'h80001010, 1, 1, 32'hC4, 32'hC5, 2'd0, 1);
    mmu_respond(0, 32'h80001018, 1, 1, 32'hC6, 32'hC7, 2'd1, 1);
    check("wrap_wait_en", 64'(inst_en), 64'd0);
    check("wrap_addr",    64'(inst_addr), 64'h80001020);
    check("wrap_head",    {out_pc_1, out_inst_1}, {32'h80001004, 32'hC1});
    deq(2); deq(2); deq(2);
    mmu_respond(0, 32'h80001020, 1, 1, 32'hC8, 32'hC9, 2'd0, 1);
    check("wrap_read_2", {out_pc_2, out_inst_2}, {32'h80001020, 32'hC8});
    deq(2); deq(1);
    check("final_empty", 64'(out_valid_1), 64'd0);
    check("sb_drained",  64'(exp_q.size()), 64'd0);
`ifdef IFQ_PERF_CNT_EN
    check("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'd26);
    check("perf_full_cyc",  64'(perf_full_cyc),  64'd2);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
